// File: rtl/sport1_rx_deser.sv
// SPORT1 receive deserializer: frames DR bits into words and holds them in a one-entry buffer.
// Build option: define FD_SPORT1_SEXT_EN to sign-extend words shorter than DW.
module sport1_rx_deser #(
    parameter int unsigned DW = 16,
    parameter int unsigned CW = 5
) (
    input  logic          DSPCLK,
    input  logic          RST_,
    input  logic          SP_EN,
    input  logic          SCLK_en,
    input  logic          RFSsm,
    input  logic          DR,
    input  logic [CW-1:0] SLEN,
    input  logic          MSBF,
    input  logic          RX_RD,
    input  logic          ROVF_CLR,
    output logic [DW-1:0] RX_DATA,
    output logic          RX_VLD,
    output logic          RX_IRQ,
    output logic          ROVF,
    output logic          RFERR,
    output logic          RX_BUSY
);

`ifdef FD_SPORT1_SEXT_EN
    localparam bit SExt = 1'b1;
`else
    localparam bit SExt = 1'b0;
`endif

    typedef enum logic {StIdle, StShift} state_e;

    state_e        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [3:0]    len_q, len_d;
    logic [DW-1:0] sr_q, sr_d;
    logic          done_q, done_d;
    logic [DW-1:0] data_q, data_d;
    logic          vld_q, vld_d;
    logic          irq_q, irq_d;
    logic          rovf_q, rovf_d;
    logic          rferr_q, rferr_d;

    logic          ferr_set;
    logic [3:0]    len_new;
    logic [3:0]    bit_idx;
    logic [DW-1:0] sr_first;
    logic [DW-1:0] sr_shift;
    logic [DW-1:0] word;
    logic          unused_slen;

    assign unused_slen = ^SLEN[CW-1:4];

    // len holds L-1, which is also the counter value loaded at frame start
    assign len_new  = (SLEN[3:0] < 4'd2) ? 4'd2 : SLEN[3:0];
    assign bit_idx  = len_q - cnt_q + 4'd1;
    assign sr_first = {{(DW-1){1'b0}}, DR};

    always_comb begin
        sr_shift = sr_q;
        if (MSBF) begin
            sr_shift = {sr_q[DW-2:0], DR};
        end else begin
            sr_shift[bit_idx] = DR;
        end
    end

    always_comb begin
        word = sr_q;
        for (int i = 0; i < DW; i++) begin
            if (i > int'(len_q)) begin
                word[i] = SExt & sr_q[len_q];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        len_d    = len_q;
        sr_d     = sr_q;
        done_d   = 1'b0;
        ferr_set = 1'b0;
        if (!SP_EN) begin
            state_d = StIdle;
            cnt_d   = 4'd0;
        end else if (SCLK_en) begin
            case (state_q)
                StIdle: begin
                    if (RFSsm) begin
                        state_d = StShift;
                        cnt_d   = len_new;
                        len_d   = len_new;
                        sr_d    = sr_first;
                    end
                end
                StShift: begin
                    // a frame sync on the last bit is just data
                    if (cnt_q == 4'd1) begin
                        state_d = StIdle;
                        cnt_d   = 4'd0;
                        sr_d    = sr_shift;
                        done_d  = 1'b1;
                    end else if (RFSsm) begin
                        ferr_set = 1'b1;
                        cnt_d    = len_new;
                        len_d    = len_new;
                        sr_d     = sr_first;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                        sr_d  = sr_shift;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        data_d  = data_q;
        vld_d   = vld_q;
        irq_d   = done_q;
        rovf_d  = rovf_q;
        rferr_d = rferr_q;
        if (done_q) begin
            data_d = word;
            vld_d  = 1'b1;
        end else if (RX_RD) begin
            vld_d = 1'b0;
        end
        if (done_q && vld_q && !RX_RD) begin
            rovf_d = 1'b1;
        end else if (ROVF_CLR) begin
            rovf_d = 1'b0;
        end
        if (ferr_set) begin
            rferr_d = 1'b1;
        end else if (ROVF_CLR) begin
            rferr_d = 1'b0;
        end
    end

    always_ff @(posedge DSPCLK or negedge RST_) begin
        if (!RST_) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            len_q   <= 4'd0;
            sr_q    <= '0;
            done_q  <= 1'b0;
            data_q  <= '0;
            vld_q   <= 1'b0;
            irq_q   <= 1'b0;
            rovf_q  <= 1'b0;
            rferr_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            sr_q    <= sr_d;
            done_q  <= done_d;
            data_q  <= data_d;
            vld_q   <= vld_d;
            irq_q   <= irq_d;
            rovf_q  <= rovf_d;
            rferr_q <= rferr_d;
        end
    end

    assign RX_DATA = data_q;
    assign RX_VLD  = vld_q;
    assign RX_IRQ  = irq_q;
    assign ROVF    = rovf_q;
    assign RFERR   = rferr_q;
    assign RX_BUSY = (state_q == StShift);

endmodule

// File: tb/tb_sport1_rx_deser.sv
// Randomized bench for sport1_rx_deser against a word-level model of the receive buffer.
// Honours FD_SPORT1_SEXT_EN the same way the design does.
module tb_sport1_rx_deser;

    logic        DSPCLK = 1'b0;
    logic        RST_, SP_EN, SCLK_en, RFSsm, DR, MSBF, RX_RD, ROVF_CLR;
    logic [4:0]  SLEN;
    logic [15:0] RX_DATA;
    logic        RX_VLD, RX_IRQ, ROVF, RFERR, RX_BUSY;

    int n_chk;
    int n_pass;

    logic [15:0] m_data;
    bit          m_vld, m_rovf, m_rferr;

`ifdef FD_SPORT1_SEXT_EN
    localparam logic [15:0] ExpB2 = 16'hFFB2;
    localparam logic [15:0] Exp06 = 16'hFFFE;
`else
    localparam logic [15:0] ExpB2 = 16'h00B2;
    localparam logic [15:0] Exp06 = 16'h0006;
`endif

    sport1_rx_deser dut (
        .DSPCLK  (DSPCLK),
        .RST_    (RST_),
        .SP_EN   (SP_EN),
        .SCLK_en (SCLK_en),
        .RFSsm   (RFSsm),
        .DR      (DR),
        .SLEN    (SLEN),
        .MSBF    (MSBF),
        .RX_RD   (RX_RD),
        .ROVF_CLR(ROVF_CLR),
        .RX_DATA (RX_DATA),
        .RX_VLD  (RX_VLD),
        .RX_IRQ  (RX_IRQ),
        .ROVF    (ROVF),
        .RFERR   (RFERR),
        .RX_BUSY (RX_BUSY)
    );

    always #5 DSPCLK = ~DSPCLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    endtask

    function automatic int eff_len(input logic [4:0] s);
        int v;
        v = int'(s[3:0]);
        if (v < 2) v = 2;
        return v + 1;
    endfunction

    // s[k] is the k-th bit on the wire
    function automatic logic [15:0] ref_word(input int l, input bit msbf, input logic [15:0] s);
        logic [15:0] w;
        int pos;
        w = '0;
        for (int k = 0; k < l; k++) begin
            pos = msbf ? (l - 1 - k) : k;
            w = w | (16'(s[k]) << pos);
        end
`ifdef FD_SPORT1_SEXT_EN
        if (w[l-1]) w = w | (16'hFFFF << l);
`endif
        return w;
    endfunction

    task automatic tick();
        @(posedge DSPCLK);
        #1;
    endtask

    task automatic check_outs(input string tag);
        check({tag, ".data"}, 32'(RX_DATA), 32'(m_data));
        check({tag, ".vld"}, 32'(RX_VLD), 32'(m_vld));
        check({tag, ".rovf"}, 32'(ROVF), 32'(m_rovf));
        check({tag, ".rferr"}, 32'(RFERR), 32'(m_rferr));
    endtask

    task automatic gap();
        int n;
        n = $urandom_range(0, 2);
        repeat (n) begin
            DR    = 1'($urandom);
            RFSsm = 1'($urandom);
            tick();
        end
        RFSsm = 1'b0;
    endtask

    task automatic send_bit(input bit fs, input bit d);
        SCLK_en = 1'b1;
        RFSsm   = fs;
        DR      = d;
        tick();
        SCLK_en = 1'b0;
        RFSsm   = 1'b0;
    endtask

    // Called just after the edge that took the last bit.
    task automatic finish_word(input int l, input bit msbf, input logic [15:0] s, input bit rd,
                               input string tag);
        check({tag, ".busy_end"}, 32'(RX_BUSY), 32'd0);
        check({tag, ".irq_early"}, 32'(RX_IRQ), 32'd0);
        RX_RD = rd;
        tick();
        RX_RD = 1'b0;
        if (m_vld && !rd) m_rovf = 1'b1;
        m_vld  = 1'b1;
        m_data = ref_word(l, msbf, s);
        check({tag, ".irq"}, 32'(RX_IRQ), 32'd1);
        check_outs(tag);
        tick();
        check({tag, ".irq_off"}, 32'(RX_IRQ), 32'd0);
    endtask

    task automatic word(input logic [4:0] slen, input bit msbf, input logic [15:0] s, input bit rd,
                        input bit last_fs, input string tag);
        int l;
        l    = eff_len(slen);
        SLEN = slen;
        MSBF = msbf;
        for (int k = 0; k < l; k++) begin
            send_bit((k == 0) || (last_fs && k == l - 1), s[k]);
            if (k == 0) begin
                check({tag, ".busy"}, 32'(RX_BUSY), 32'd1);
                check({tag, ".rferr0"}, 32'(RFERR), 32'(m_rferr));
            end
            if (k < l - 1) begin
                SLEN = 5'($urandom);
                gap();
            end
        end
        finish_word(l, msbf, s, rd, tag);
    endtask

    task automatic abort_word(input logic [4:0] slen1, input bit msbf, input logic [15:0] s1,
                              input int ak, input logic [4:0] slen2, input logic [15:0] s2,
                              input bit rd, input string tag);
        SLEN = slen1;
        MSBF = msbf;
        for (int k = 0; k < ak; k++) begin
            send_bit(k == 0, s1[k]);
            gap();
        end
        m_rferr = 1'b1;
        word(slen2, msbf, s2, rd, 1'b0, tag);
    endtask

    task automatic idle_ops();
        RX_RD    = 1'($urandom);
        ROVF_CLR = 1'($urandom);
        tick();
        if (RX_RD) m_vld = 1'b0;
        if (ROVF_CLR) begin
            m_rovf  = 1'b0;
            m_rferr = 1'b0;
        end
        RX_RD    = 1'b0;
        ROVF_CLR = 1'b0;
        check("idle.irq", 32'(RX_IRQ), 32'd0);
        check_outs("idle");
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".data"}, 32'(RX_DATA), 32'd0);
        check({tag, ".vld"}, 32'(RX_VLD), 32'd0);
        check({tag, ".irq"}, 32'(RX_IRQ), 32'd0);
        check({tag, ".rovf"}, 32'(ROVF), 32'd0);
        check({tag, ".rferr"}, 32'(RFERR), 32'd0);
        check({tag, ".busy"}, 32'(RX_BUSY), 32'd0);
    endtask

    initial begin
        n_chk = 0; n_pass = 0;
        RST_ = 1'b0; SP_EN = 1'b1; SCLK_en = 1'b0; RFSsm = 1'b0; DR = 1'b0;
        SLEN = 5'd7; MSBF = 1'b1; RX_RD = 1'b0; ROVF_CLR = 1'b0;
        m_data = '0; m_vld = 1'b0; m_rovf = 1'b0; m_rferr = 1'b0;
        #12;
        check_all_zero("reset");
        #5 RST_ = 1'b1;
        tick();

        // Stream 1,0,1,1,0,0,1,0 is s = 0x004D (bit k = k-th bit on the wire)
        word(5'd7, 1'b1, 16'h004D, 1'b0, 1'b0, "msbf8");
        check("msbf8.const", 32'(RX_DATA), 32'(ExpB2));
        word(5'd7, 1'b0, 16'h004D, 1'b0, 1'b1, "lsbf8");
        check("lsbf8.const", 32'(RX_DATA), 32'h004D);
        check("lsbf8.ovf", 32'(ROVF), 32'd1);
        ROVF_CLR = 1'b1;
        tick();
        ROVF_CLR = 1'b0;
        m_rovf = 1'b0; m_rferr = 1'b0;
        check("ovf_clr", 32'(ROVF), 32'd0);
        word(5'd7, 1'b1, 16'($urandom), 1'b1, 1'b0, "rdload");
        check("rdload.ovf", 32'(ROVF), 32'd0);
        word(5'd0, 1'b1, 16'h0003, 1'b1, 1'b0, "len3");
        check("len3.const", 32'(RX_DATA), 32'(Exp06));

        abort_word(5'd15, 1'b1, 16'($urandom), 5, 5'd15, 16'($urandom), 1'b1, "abort");
        check("abort.rferr", 32'(RFERR), 32'd1);
        idle_ops();

        // SP_EN drop at bit 3
        SLEN = 5'd7; MSBF = 1'b1;
        for (int k = 0; k < 3; k++) begin
            send_bit(k == 0, 1'($urandom));
            gap();
        end
        SP_EN = 1'b0; SCLK_en = 1'b1; RFSsm = 1'b1; DR = 1'b1;
        tick();
        check("spen.busy", 32'(RX_BUSY), 32'd0);
        tick();
        SCLK_en = 1'b0; RFSsm = 1'b0;
        check("spen.busy2", 32'(RX_BUSY), 32'd0);
        tick();
        check("spen.irq", 32'(RX_IRQ), 32'd0);
        check_outs("spen");
        SP_EN = 1'b1;
        word(5'd7, 1'b0, 16'($urandom), 1'b1, 1'b0, "after_spen");

        // Reset at bit 4
        SLEN = 5'd9; MSBF = 1'b0;
        for (int k = 0; k < 4; k++) begin
            send_bit(k == 0, 1'($urandom));
            gap();
        end
        check("prerst.busy", 32'(RX_BUSY), 32'd1);
        RST_ = 1'b0;
        #1;
        check_all_zero("midrst");
        m_data = '0; m_vld = 1'b0; m_rovf = 1'b0; m_rferr = 1'b0;
        #2 RST_ = 1'b1;
        tick();
        check_all_zero("postrst");
        word(5'd12, 1'b1, 16'($urandom), 1'b0, 1'b0, "post_rst");

        for (int n = 0; n < 150; n++) begin
            logic [4:0]  sl;
            logic [15:0] s;
            bit          mb, rd, lf;
            int          l;
            sl = 5'($urandom);
            s  = 16'($urandom);
            mb = 1'($urandom);
            rd = ($urandom_range(0, 2) == 0);
            lf = 1'($urandom);
            if ($urandom_range(0, 5) == 0) begin
                l = eff_len(sl);
                abort_word(sl, mb, 16'($urandom), $urandom_range(1, l - 2), 5'($urandom), s, rd,
                           "rnd_abort");
            end else begin
                word(sl, mb, s, rd, lf, "rnd");
            end
            if ($urandom_range(0, 1) == 1) idle_ops();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
